// File: rtl/cpu_defs_pkg.sv
// Shared CPU definitions: boot/exception vectors, the fetch-to-decode record
// and the fetch state encoding.
package cpu_defs_pkg;

  localparam logic [31:0] CPU_RESET_PC   = 32'hBFC00000;
  localparam logic [31:0] CPU_EXC_VECTOR = 32'hBFC00380;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
    logic        addr_err_if;
    logic        in_delay_slot;
    logic        is_instr;
  } dp_ftod;

  typedef enum logic [1:0] {
    StReq,
    StWait,
    StFull,
    StKill
  } fetch_state_e;

  // An empty fetch-to-decode slot: decode sees a NOP with no flags set.
  function automatic dp_ftod ftod_empty(input logic [31:0] nop_instr);
    dp_ftod r;
    r.pc            = 32'h0;
    r.instr         = nop_instr;
    r.addr_err_if   = 1'b0;
    r.in_delay_slot = 1'b0;
    r.is_instr      = 1'b0;
    return r;
  endfunction

endpackage

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: fetch PC, single-outstanding SRAM-like request FSM and the
// registered fetch-to-decode record. Define FETCH_PERF_CNT_EN to enable fetch_stall_cnt.
module fetch_unit
  import cpu_defs_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = CPU_RESET_PC,
  parameter logic [31:0] NOP_INSTR = 32'h00000000
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic [31:0] f_nextpc,
  input  logic        f_indelayslot,
  input  logic        d_stall,
  input  logic        flush,
  input  logic [31:0] inst_rdata,
  input  logic        inst_addr_ok,
  input  logic        inst_data_ok,
  output logic        inst_req,
  output logic        inst_wr,
  output logic [1:0]  inst_size,
  output logic [31:0] inst_addr,
  output logic [31:0] inst_wdata,
  output logic [31:0] f_nowpc,
  output dp_ftod      ftod,
  output logic [31:0] fetch_stall_cnt
);

  fetch_state_e state_q, state_d;
  logic [31:0]  pc_q, pc_d;
  logic         dly_q, dly_d;
  logic [31:0]  buf_instr_q, buf_instr_d;
  logic         buf_err_q, buf_err_d;
  dp_ftod       ftod_q, ftod_d;

  logic         slot_free;
  logic         pc_misaligned;
  logic         xfer;
  logic [31:0]  xfer_instr;
  logic         xfer_err;

  assign slot_free     = !ftod_q.is_instr || !d_stall;
  assign pc_misaligned = (pc_q[1:0] != 2'b00);

  assign inst_wr    = 1'b0;
  assign inst_size  = 2'b10;
  assign inst_wdata = 32'h0;
  assign inst_addr  = pc_q;
  assign f_nowpc    = pc_q;
  assign ftod       = ftod_q;

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    dly_d       = dly_q;
    buf_instr_d = buf_instr_q;
    buf_err_d   = buf_err_q;
    ftod_d      = ftod_q;
    inst_req    = 1'b0;
    xfer        = 1'b0;
    xfer_instr  = buf_instr_q;
    xfer_err    = buf_err_q;

    unique case (state_q)
      StReq: begin
        // A misaligned PC never reaches memory; the error rides a NOP into decode.
        if (pc_misaligned) begin
          state_d     = StFull;
          buf_instr_d = NOP_INSTR;
          buf_err_d   = 1'b1;
        end else begin
          inst_req = 1'b1;
          if (inst_addr_ok) state_d = StWait;
        end
      end
      StWait: begin
        if (inst_data_ok) begin
          if (slot_free) begin
            xfer       = 1'b1;
            xfer_instr = inst_rdata;
            xfer_err   = 1'b0;
          end else begin
            state_d     = StFull;
            buf_instr_d = inst_rdata;
            buf_err_d   = 1'b0;
          end
        end
      end
      StFull: xfer = slot_free;
      StKill: if (inst_data_ok) state_d = StReq;
      default: state_d = StReq;
    endcase

    if (flush) begin
      ftod_d      = ftod_empty(NOP_INSTR);
      pc_d        = f_nextpc;
      dly_d       = 1'b0;
      buf_instr_d = NOP_INSTR;
      buf_err_d   = 1'b0;
      // An accepted but unanswered request must be drained before refetching.
      unique case (state_q)
        StReq:   state_d = (!pc_misaligned && inst_addr_ok) ? StKill : StReq;
        StWait:  state_d = inst_data_ok ? StReq : StKill;
        StKill:  state_d = inst_data_ok ? StReq : StKill;
        default: state_d = StReq;
      endcase
    end else if (xfer) begin
      ftod_d.pc            = pc_q;
      ftod_d.instr         = xfer_instr;
      ftod_d.addr_err_if   = xfer_err;
      ftod_d.in_delay_slot = dly_q;
      ftod_d.is_instr      = 1'b1;
      pc_d                 = f_nextpc;
      dly_d                = f_indelayslot;
      state_d              = StReq;
    end else if (slot_free) begin
      ftod_d = ftod_empty(NOP_INSTR);
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q     <= StReq;
      pc_q        <= RESET_PC;
      dly_q       <= 1'b0;
      buf_instr_q <= NOP_INSTR;
      buf_err_q   <= 1'b0;
      ftod_q      <= ftod_empty(NOP_INSTR);
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      dly_q       <= dly_d;
      buf_instr_q <= buf_instr_d;
      buf_err_q   <= buf_err_d;
      ftod_q      <= ftod_d;
    end
  end

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] cnt_q;
  logic        stall_cycle;

  assign stall_cycle = ((state_q == StReq) && !inst_addr_ok) ||
                       (((state_q == StWait) || (state_q == StKill)) && !inst_data_ok);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      cnt_q <= 32'h0;
    end else if (stall_cycle) begin
      cnt_q <= cnt_q + 32'd1;
    end
  end

  assign fetch_stall_cnt = cnt_q;
`else
  assign fetch_stall_cnt = 32'h0;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed table, multi-cycle corner sequences and a
// randomized run against a transaction-level expectation of the fetched stream.
module tb_fetch_unit;
  import cpu_defs_pkg::*;

  localparam logic [31:0] BootPc = 32'hBFC00000;
  localparam logic [31:0] Nop    = 32'h00000000;

  logic        clk = 1'b0;
  logic        resetn;
  logic [31:0] f_nextpc;
  logic        f_indelayslot;
  logic        d_stall;
  logic        flush;
  logic [31:0] inst_rdata;
  logic        inst_addr_ok;
  logic        inst_data_ok;
  logic        inst_req;
  logic        inst_wr;
  logic [1:0]  inst_size;
  logic [31:0] inst_addr;
  logic [31:0] inst_wdata;
  logic [31:0] f_nowpc;
  dp_ftod      ftod;
  logic [31:0] fetch_stall_cnt;

  int n_chk  = 0;
  int n_fail = 0;

  fetch_unit dut (
    .clk            (clk),
    .resetn         (resetn),
    .f_nextpc       (f_nextpc),
    .f_indelayslot  (f_indelayslot),
    .d_stall        (d_stall),
    .flush          (flush),
    .inst_rdata     (inst_rdata),
    .inst_addr_ok   (inst_addr_ok),
    .inst_data_ok   (inst_data_ok),
    .inst_req       (inst_req),
    .inst_wr        (inst_wr),
    .inst_size      (inst_size),
    .inst_addr      (inst_addr),
    .inst_wdata     (inst_wdata),
    .f_nowpc        (f_nowpc),
    .ftod           (ftod),
    .fetch_stall_cnt(fetch_stall_cnt)
  );

  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: got no end of test, expected $finish before timeout");
    $fatal(1, "timeout");
  end

  typedef struct {
    logic [31:0] nextpc;
    logic        dly;
    logic [31:0] rdata;
    int          alat;
    int          dlat;
    logic [31:0] exp_pc;
    logic [31:0] exp_instr;
    logic        exp_err;
    logic        exp_dly;
  } vec_t;

  function automatic dp_ftod mk_rec(input logic [31:0] pc, input logic [31:0] instr,
                                    input logic err, input logic dly, input logic v);
    dp_ftod r;
    r.pc = pc; r.instr = instr; r.addr_err_if = err; r.in_delay_slot = dly; r.is_instr = v;
    return r;
  endfunction

  function automatic logic [31:0] word_of(input logic [31:0] a);
    return {a[15:0], ~a[15:0]} ^ 32'h1357_9BDF;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chk_rec(input string name, input dp_ftod act, input dp_ftod exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got pc=%h instr=%h err=%b dly=%b v=%b expected pc=%h instr=%h err=%b dly=%b v=%b",
               name, act.pc, act.instr, act.addr_err_if, act.in_delay_slot, act.is_instr,
               exp.pc, exp.instr, exp.addr_err_if, exp.in_delay_slot, exp.is_instr);
    end
  endtask

  // One memory transaction with the given accept and data latencies; ends on the
  // negedge just after the data_ok edge.
  task automatic mem_txn(input logic [31:0] rdata, input int alat, input int dlat,
                         input logic [31:0] exp_addr);
    int n;
`ifdef FETCH_PERF_CNT_EN
    logic [31:0] c0;
`endif
    n = 0;
    while (!inst_req && n < 8) begin
      @(negedge clk);
      n++;
    end
    chk("req_issued", 32'(inst_req), 32'd1);
    chk("req_addr", inst_addr, exp_addr);
`ifdef FETCH_PERF_CNT_EN
    c0 = fetch_stall_cnt;
`endif
    for (int k = 0; k < alat; k++) begin
      @(negedge clk);
      chk("req_held", 32'(inst_req), 32'd1);
    end
    inst_addr_ok = 1'b1;
    @(negedge clk);
    inst_addr_ok = 1'b0;
    chk("one_outstanding", 32'(inst_req), 32'd0);
    repeat (dlat) @(negedge clk);
    inst_data_ok = 1'b1;
    inst_rdata   = rdata;
    @(negedge clk);
    inst_data_ok = 1'b0;
    inst_rdata   = 32'hDEAD_BEEF;
`ifdef FETCH_PERF_CNT_EN
    chk("stall_cnt_delta", fetch_stall_cnt - c0, 32'(alat + dlat));
`else
    chk("stall_cnt_zero", fetch_stall_cnt, 32'h0);
`endif
  endtask

  vec_t        vecs [6];
  dp_ftod      saved;
  logic [31:0] exp_pc, nt, pend_addr, addr_s;
  logic        exp_dly, nd, have_rec, pend, req_s, valid_s;
  int          lat, n_rec, nw;

  initial begin
    vecs[0] = '{32'hBFC00004, 1'b0, 32'h24080001, 0, 0, 32'hBFC00000, 32'h24080001, 1'b0, 1'b0};
    vecs[1] = '{32'hBFC00100, 1'b1, 32'h10000040, 1, 0, 32'hBFC00004, 32'h10000040, 1'b0, 1'b0};
    vecs[2] = '{32'hBFC00104, 1'b0, 32'h3C010000, 0, 1, 32'hBFC00100, 32'h3C010000, 1'b0, 1'b1};
    vecs[3] = '{32'hBFC00102, 1'b0, 32'h8C220000, 0, 2, 32'hBFC00104, 32'h8C220000, 1'b0, 1'b0};
    vecs[4] = '{32'hBFC00200, 1'b0, 32'h0BADF00D, 0, 0, 32'hBFC00102, Nop,          1'b1, 1'b0};
    vecs[5] = '{32'hBFC00204, 1'b0, 32'hAFBF0010, 4, 1, 32'hBFC00200, 32'hAFBF0010, 1'b0, 1'b0};

    resetn = 1'b0; d_stall = 1'b0; flush = 1'b0; inst_addr_ok = 1'b0; inst_data_ok = 1'b0;
    inst_rdata = 32'hDEAD_BEEF;
    f_nextpc = vecs[0].nextpc; f_indelayslot = vecs[0].dly;

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_nowpc", f_nowpc, BootPc);
    chk("rst_addr", inst_addr, BootPc);
    chk_rec("rst_ftod", ftod, mk_rec(32'h0, Nop, 1'b0, 1'b0, 1'b0));
    chk("rst_cnt", fetch_stall_cnt, 32'h0);
    chk("const_wr", 32'(inst_wr), 32'h0);
    chk("const_size", 32'(inst_size), 32'h2);
    chk("const_wdata", inst_wdata, 32'h0);
    resetn = 1'b1;

    // Directed single fetches; each entry's f_nextpc is the next entry's PC.
    for (int i = 0; i < 6; i++) begin
      if (!vecs[i].exp_err) begin
        mem_txn(vecs[i].rdata, vecs[i].alat, vecs[i].dlat, vecs[i].exp_pc);
        chk("latency", 32'(ftod.is_instr), 32'd1);
      end else begin
        nw = 0;
        while (!ftod.is_instr && nw < 6) begin
          @(negedge clk);
          nw++;
        end
      end
      chk_rec("table_rec", ftod, mk_rec(vecs[i].exp_pc, vecs[i].exp_instr, vecs[i].exp_err,
                                        vecs[i].exp_dly, 1'b1));
      chk("table_nowpc", f_nowpc, vecs[i].nextpc);
      if (vecs[i].nextpc[1:0] != 2'b00) chk("misaligned_noreq", 32'(inst_req), 32'd0);
      if (i < 5) begin
        f_nextpc = vecs[i+1].nextpc;
        f_indelayslot = vecs[i+1].dly;
      end
      @(negedge clk);
      chk("bubble", 32'(ftod.is_instr), 32'd0);
    end

    // Decode stall: the next word parks in the buffer while ftod is held.
    f_nextpc = 32'hBFC00208; f_indelayslot = 1'b0;
    mem_txn(32'h11111111, 4, 0, 32'hBFC00204);
    chk_rec("stall_r1", ftod, mk_rec(32'hBFC00204, 32'h11111111, 1'b0, 1'b0, 1'b1));
    d_stall = 1'b1; f_nextpc = 32'hBFC0020C;
    mem_txn(32'h22222222, 0, 0, 32'hBFC00208);
    for (int k = 0; k < 3; k++) begin
      chk_rec("stall_hold", ftod, mk_rec(32'hBFC00204, 32'h11111111, 1'b0, 1'b0, 1'b1));
      chk("stall_noreq", 32'(inst_req), 32'd0);
      chk("stall_nowpc", f_nowpc, 32'hBFC00208);
      if (k < 2) @(negedge clk);
    end
    d_stall = 1'b0;
    @(negedge clk);
    chk_rec("stall_r2", ftod, mk_rec(32'hBFC00208, 32'h22222222, 1'b0, 1'b0, 1'b1));
    chk("stall_nowpc2", f_nowpc, 32'hBFC0020C);

    // Flush while waiting for data: the late word is discarded, dly flag cleared.
    f_nextpc = 32'hBFC00210; f_indelayslot = 1'b1;
    mem_txn(32'h33333333, 0, 0, 32'hBFC0020C);
    chk_rec("flush_r3", ftod, mk_rec(32'hBFC0020C, 32'h33333333, 1'b0, 1'b0, 1'b1));
    chk("flush_req_addr", inst_addr, 32'hBFC00210);
    inst_addr_ok = 1'b1;
    @(negedge clk);
    inst_addr_ok = 1'b0;
    flush = 1'b1; f_nextpc = 32'hBFC00380; f_indelayslot = 1'b1;
    @(negedge clk);
    flush = 1'b0; f_nextpc = 32'hBFC00384; f_indelayslot = 1'b0;
    chk("kill_noreq", 32'(inst_req), 32'd0);
    chk("kill_bubble", 32'(ftod.is_instr), 32'd0);
    chk("kill_nowpc", f_nowpc, 32'hBFC00380);
    @(negedge clk);
    chk("kill_noreq2", 32'(inst_req), 32'd0);
    inst_data_ok = 1'b1; inst_rdata = 32'hBAADBAAD;
    @(negedge clk);
    inst_data_ok = 1'b0; inst_rdata = 32'hDEAD_BEEF;
    chk("kill_junk_dropped", 32'(ftod.is_instr), 32'd0);
    chk("kill_refetch", 32'(inst_req), 32'd1);
    mem_txn(32'h44444444, 1, 1, 32'hBFC00380);
    chk_rec("flush_target", ftod, mk_rec(32'hBFC00380, 32'h44444444, 1'b0, 1'b0, 1'b1));
    chk("flush_nowpc", f_nowpc, 32'hBFC00384);

    // Reset asserted with a request in flight.
    inst_addr_ok = 1'b1;
    @(negedge clk);
    inst_addr_ok = 1'b0;
    #2 resetn = 1'b0;
    #1;
    chk("midrst_nowpc", f_nowpc, BootPc);
    chk_rec("midrst_ftod", ftod, mk_rec(32'h0, Nop, 1'b0, 1'b0, 1'b0));
    chk("midrst_cnt", fetch_stall_cnt, 32'h0);

    // Randomized run: the delivered stream must follow the PC chain the bench supplies.
    exp_pc = BootPc; exp_dly = 1'b0; nt = BootPc + 32'd4; nd = 1'b0;
    have_rec = 1'b0; pend = 1'b0; lat = 0; n_rec = 0; pend_addr = 32'h0;
    f_nextpc = nt; f_indelayslot = nd;
    @(negedge clk);
    resetn = 1'b1;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      @(negedge clk);
      if (have_rec) begin
        chk_rec("rand_hold", ftod, saved);
      end else if (ftod.is_instr) begin
        chk_rec("rand_rec", ftod, mk_rec(exp_pc, word_of(exp_pc), 1'b0, exp_dly, 1'b1));
        saved = ftod; have_rec = 1'b1; n_rec++;
        exp_pc = nt; exp_dly = nd;
        if ($urandom_range(3) == 0) begin
          nt = 32'hBFC00000 | ($urandom & 32'h0000FFFC);
          nd = 1'b1;
        end else begin
          nt = exp_pc + 32'd4;
          nd = 1'b0;
        end
      end
      if (inst_req) begin
        chk("rand_req_addr", inst_addr, exp_pc);
        chk("rand_one_outstanding", 32'(pend), 32'd0);
      end
      f_nextpc      = nt;
      f_indelayslot = nd;
      d_stall       = ($urandom_range(9) < 4);
      inst_addr_ok  = inst_req && !pend && ($urandom_range(9) < 6);
      inst_data_ok  = pend && (lat == 0);
      inst_rdata    = inst_data_ok ? word_of(pend_addr) : $urandom;
      req_s = inst_req; addr_s = inst_addr; valid_s = ftod.is_instr;
      @(posedge clk);
      if (req_s && inst_addr_ok) begin
        pend = 1'b1; pend_addr = addr_s; lat = $urandom_range(3);
      end else if (pend) begin
        if (inst_data_ok) pend = 1'b0;
        else lat--;
      end
      if (valid_s && !d_stall) have_rec = 1'b0;
    end
    chk("rand_progress", 32'(n_rec >= 200), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction-fetch stage of the 5-stage MIPS pipeline; the producer side of the fetch-to-decode interface.
- Holds the fetch PC, presents it to decode as f_nowpc, and issues one SRAM-like instruction request at a time.
- Captures the returned word and delivers a dp_ftod record (pc, instr, addr_err_if, in_delay_slot, is_instr) into decode.
- Takes f_nextpc / f_indelayslot back from decode, plus stall and flush from the hazard/exception logic.

Parameters:
- RESET_PC, 32'hBFC00000, fetch PC after reset.
- NOP_INSTR, 32'h00000000, instr value driven when the ftod slot is empty or on a fetch address error.

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- resetn  input  1  asynchronous, active-low reset.
- f_nextpc  input  32  next fetch PC, computed by decode from f_nowpc.
- f_indelayslot  input  1  the instruction in decode is a branch or jump.
- d_stall  input  1  decode cannot accept a new ftod this cycle.
- flush  input  1  exception/eret redirect; f_nextpc already carries the target.
- inst_rdata  input  32  instruction SRAM read data.
- inst_addr_ok  input  1  request address accepted.
- inst_data_ok  input  1  read data valid.
- inst_req  output  1  request valid.
- inst_wr  output  1  constant 0.
- inst_size  output  2  constant 2'b10.
- inst_addr  output  32  equals pc_q.
- inst_wdata  output  32  constant 0.
- f_nowpc  output  32  current fetch PC (pc_q).
- ftod  output  dp_ftod  registered record to decode; is_instr=1 means valid.
- fetch_stall_cnt  output  32  performance counter (see Optional Feature).

Behaviour:
- Reset (async): pc_q=RESET_PC; state=REQ; ftod cleared (pc=0, instr=NOP_INSTR, flags 0); delay-slot flag=0; buffer empty; counter=0.
- slot_free = (ftod.is_instr==0) || (d_stall==0).
- State REQ:
  - If pc_q[1:0]!=0: no request; inst_req=0; go to FULL with buffer={NOP_INSTR, addr_err=1}.
  - Otherwise inst_req=1. addr_ok=1 -> WAIT; addr_ok=0 -> stay in REQ.
- State WAIT:
  - On data_ok, capture inst_rdata into the buffer.
  - If slot_free in the same cycle, bypass the buffer and load ftod directly.
- State FULL: buffered word waits until slot_free.
- Transfer edge (fetch result enters ftod):
  - ftod loads {pc_q, word, addr_err, dly_q, 1}; dly_q is the delay-slot flag.
  - pc_q <= f_nextpc; dly_q <= f_indelayslot; state -> REQ.
  - Latency: data_ok at cycle N gives ftod valid at N+1, provided slot_free.
- No transfer but slot_free: ftod.is_instr <= 0 (bubble).
- ftod.is_instr=0 while d_stall=1: the bubble is held. ftod.is_instr=1 while d_stall=1: ftod is held unchanged.
- Max one outstanding transaction. A new request is issued only after the previous data_ok.
- Flush has priority over all other events:
  - ftod.is_instr <= 0; buffer dropped; pc_q <= f_nextpc; dly_q <= 0.
  - From REQ with addr_ok=0: next state REQ.
  - From REQ with addr_ok=1, or from WAIT without data_ok: next state KILL.
  - From FULL, or WAIT with data_ok: next state REQ.
- State KILL: inst_req=0; wait for data_ok, discard the data, then -> REQ.
- While ftod.is_instr=0, decode sees NOP_INSTR, so f_nextpc = f_nowpc+4 (sequential fetch).
- Reset asserted mid-transaction: all state cleared immediately. The memory side is reset together with the core.

Optional Feature:
- Macro FETCH_PERF_CNT_EN.
- Defined: fetch_stall_cnt increments (wrapping) every cycle the state is REQ with addr_ok=0, or WAIT/KILL without data_ok. Resets to 0.
- Undefined: no counter register; fetch_stall_cnt tied to 0.

Decomposition:
- dp_ftod struct and the fetch state enum (REQ, WAIT, FULL, KILL) go in the shared cpu_defs header.
- RESET_PC and exception vector 32'hBFC00380 constants also go in cpu_defs.
- No sub-module. The PC register plus FSM is one module. The existing adder is reused for nothing here (f_nextpc is supplied by decode).

Test Plan:
- Reset release; memory answers addr_ok and data_ok in 1 cycle with instr 32'h24080001 -> inst_addr=BFC00000; ftod={BFC00000, 24080001, err0, dly0, v1}; f_nowpc=BFC00004.
- d_stall=1 for 3 cycles while the next word returns -> ftod held; state FULL; inst_req=0; on release the next word loads, pc advances once.
- Branch in ftod with f_indelayslot=1, f_nextpc=BFC00100 -> delay-slot word carries in_delay_slot=1; following fetch inst_addr=BFC00100.
- flush in WAIT, data_ok 2 cycles later with junk, f_nextpc=BFC00380 -> junk never reaches ftod; next inst_addr=BFC00380; ftod.is_instr=0 meanwhile.
- f_nextpc=BFC00102 -> no inst_req; ftod.addr_err_if=1, instr=0, pc=BFC00102.
- With FETCH_PERF_CNT_EN, addr_ok delayed 4 cycles -> fetch_stall_cnt increments by 4; without the macro it reads 0.
